// File: rtl/dac_pkg.sv
// Shared types and constants for the sample_dac back end.
// Holds the output-mode codes, FSM state type and default widths.
package dac_pkg;

  localparam int DW_DEF    = 8;
  localparam int DIV_W_DEF = 8;

  localparam logic MODE_PWM = 1'b0;
  localparam logic MODE_SD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

endpackage

// File: rtl/tick_div.sv
// Tick divider: one tick every div+1 clocks while en is high.
// Ports: clk, reset (async, active-low), en, div -> tick.
module tick_div
  import dac_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= so a live shrink of div wraps a count already past it
  assign tick = en && (cnt >= div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sample_dac.sv
// Single-bit DAC: PWM or first-order sigma-delta from NCO samples.
// Ports: clk, reset, enable, mode, div, sample/valid/ready, clr_ovr,
//        dac_out, frame_start, overrun.
module sample_dac
  import dac_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
  input  logic [DW-1:0]    sample,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             clr_ovr,
  output logic             dac_out,
  output logic             frame_start,
  output logic             overrun
);

  localparam logic [DW-1:0] PMAX = '1;
  localparam logic [DW-1:0] MID  = {1'b1, {(DW-1){1'b0}}};

  state_t        state;
  state_t        nxt;
  logic          load;
  logic          run;
  logic          tick;
  logic          reload;
  logic [DW-1:0] shadow;
  logic          full;
  logic [DW-1:0] active;
  logic [DW-1:0] act_nxt;
  logic [DW-1:0] p;
  logic [DW-1:0] p_inc;
  logic [DW-1:0] acc;
  logic [DW:0]   sum;

  assign sample_ready = !full;

  tick_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .en   (run),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    nxt  = state;
    load = 1'b0;
    run  = 1'b0;
    unique case (state)
      IDLE: if (enable) nxt = LOAD;
      LOAD: begin
        load = 1'b1;
        nxt  = RUN;
      end
      RUN: begin
        if (enable) run = 1'b1;
        else        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign reload  = load || (run && tick && (p == PMAX));
  assign act_nxt = (reload && full) ? shadow : active;
  assign p_inc   = p + 1'b1;
  assign sum     = {1'b0, acc} + {1'b0, active};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow      <= '0;
      full        <= 1'b0;
      active      <= MID;
      overrun     <= 1'b0;
      frame_start <= 1'b0;
      p           <= '0;
      acc         <= '0;
      dac_out     <= 1'b0;
    end else begin
      if (sample_valid && full) overrun <= 1'b1;
      else if (clr_ovr)         overrun <= 1'b0;

      // a full shadow is never overwritten, so reload sees old content
      if (reload && full) begin
        active <= shadow;
        full   <= 1'b0;
      end else if (sample_valid && !full) begin
        shadow <= sample ^ MID;
        full   <= 1'b1;
      end

      frame_start <= reload;

      if (load) begin
        p       <= '0;
        acc     <= '0;
        dac_out <= (mode == MODE_PWM) && (act_nxt != '0);
      end else if (run) begin
        if (tick) begin
          p <= p_inc;
          // output tracks the p/active that will hold next cycle
          if (mode == MODE_SD) {dac_out, acc} <= sum;
          else                 dac_out <= (p_inc < act_nxt);
        end
      end else begin
        p       <= '0;
        acc     <= '0;
        dac_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_dac.sv
// Self-checking bench for sample_dac: directed scenarios plus
// randomized frames checked against per-frame duty arithmetic.
module tb_sample_dac;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       mode;
  logic [7:0] div;
  logic [7:0] sample;
  logic       sample_valid;
  logic       sample_ready;
  logic       clr_ovr;
  logic       dac_out;
  logic       frame_start;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sample_dac dut (
    .clk         (clk),
    .reset       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .div         (div),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .clr_ovr     (clr_ovr),
    .dac_out     (dac_out),
    .frame_start (frame_start),
    .overrun     (overrun)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fs();
    int c = 0;
    while (frame_start !== 1'b1 && c < 70000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 70000) chk("fs_timeout", 32'(frame_start), 1);
  endtask

  // Called on a frame_start cycle; counts length and high cycles
  // up to the next frame_start. Optionally offers samples at
  // cycle 0 and cycle 2 of the frame.
  task automatic measure(input int n,
                         input logic [7:0] s0,
                         input logic [7:0] s1,
                         output int len,
                         output int hi);
    len = 1;
    hi  = int'(dac_out);
    if (n > 0) begin
      sample       = s0;
      sample_valid = 1'b1;
    end
    while (1) begin
      @(negedge clk);
      sample_valid = (n > 1 && len == 2);
      if (n > 1 && len == 2) sample = s1;
      if (frame_start === 1'b1) break;
      len++;
      hi += int'(dac_out);
      if (len > 70000) begin
        chk("frame_timeout", 32'(frame_start), 1);
        break;
      end
    end
    sample_valid = 1'b0;
  endtask

  // expected sigma-delta carry of the t-th accumulation from acc=0
  function automatic int sd_bit(input int t, input int a);
    if (t == 0) return 0;
    return (t * a) / 256 - ((t - 1) * a) / 256;
  endfunction

  initial begin
    int len;
    int hi;
    int d;
    int m;
    int a;
    logic [7:0] s;

    rst_n        = 1'b0;
    enable       = 1'b0;
    mode         = 1'b0;
    div          = 8'd0;
    sample       = 8'd0;
    sample_valid = 1'b0;
    clr_ovr      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dac_out", 32'(dac_out), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_ready", 32'(sample_ready), 1);
    chk("rst_overrun", 32'(overrun), 0);

    // mid-scale default frame
    rst_n  = 1'b1;
    enable = 1'b1;
    wait_fs();
    measure(0, 8'h00, 8'h00, len, hi);
    chk("t1_len", len, 256);
    chk("t1_high", hi, 128);

    // sample 0x80 -> u=0, then 0x7F -> u=0xFF
    measure(1, 8'h80, 8'h00, len, hi);
    chk("t2_f1_high", hi, 128);
    measure(1, 8'h7F, 8'h00, len, hi);
    chk("t2_zero_high", hi, 0);
    measure(0, 8'h00, 8'h00, len, hi);
    chk("t2_full_high", hi, 255);

    // two samples in one frame: second dropped
    measure(2, 8'h10, 8'h20, len, hi);
    chk("t3_prev_high", hi, 255);
    chk("t3_overrun", 32'(overrun), 1);
    chk("t3_ready", 32'(sample_ready), 1);
    measure(0, 8'h00, 8'h00, len, hi);
    chk("t3_high", hi, 144);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("t3_clr", 32'(overrun), 0);

    // enable dropped mid-frame, then re-enabled
    repeat (8) @(negedge clk);
    chk("t5_pre_high", 32'(dac_out), 1);
    enable = 1'b0;
    @(negedge clk);
    chk("t5_off", 32'(dac_out), 0);
    repeat (3) @(negedge clk);
    chk("t5_idle", 32'(dac_out), 0);
    enable = 1'b1;
    @(negedge clk);
    chk("t5_load_fs", 32'(frame_start), 0);
    @(negedge clk);
    chk("t5_fs", 32'(frame_start), 1);
    measure(0, 8'h00, 8'h00, len, hi);
    chk("t5_len", len, 256);
    chk("t5_high", hi, 144);

    // sigma-delta, div=3, sample 0x40 -> u=0xC0
    enable = 1'b0;
    repeat (2) @(negedge clk);
    mode         = 1'b1;
    div          = 8'd3;
    sample       = 8'h40;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    enable       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_fs", 32'(frame_start), 1);
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("t4_bit%0d", k), 32'(dac_out),
          32'(sd_bit(k / 4, 192)));
      @(negedge clk);
    end
    wait_fs();
    measure(0, 8'h00, 8'h00, len, hi);
    chk("t4_len", len, 1024);
    chk("t4_high", hi, 768);

    // randomized configurations
    for (int it = 0; it < 6; it++) begin
      enable = 1'b0;
      repeat (2) @(negedge clk);
      d = int'($urandom_range(0, 3));
      m = int'($urandom_range(0, 1));
      s = 8'($urandom_range(0, 255));
      a = int'(s ^ 8'h80);
      div          = 8'(d);
      mode         = m[0];
      sample       = s;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      enable       = 1'b1;
      wait_fs();
      measure(0, 8'h00, 8'h00, len, hi);
      chk($sformatf("r%0d_len", it), len, 256 * (d + 1));
      if (m == 0)
        chk($sformatf("r%0d_f1_pwm", it), hi, a * (d + 1));
      else
        chk($sformatf("r%0d_f1_sd", it), hi,
            ((255 * a) / 256) * (d + 1));
      measure(0, 8'h00, 8'h00, len, hi);
      chk($sformatf("r%0d_f2", it), hi, a * (d + 1));
    end

    // reset mid-frame with the shadow full
    enable = 1'b0;
    repeat (2) @(negedge clk);
    mode   = 1'b0;
    div    = 8'd0;
    enable = 1'b1;
    wait_fs();
    sample       = 8'h55;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("t6_full", 32'(sample_ready), 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_dac_out", 32'(dac_out), 0);
    chk("t6_frame_start", 32'(frame_start), 0);
    chk("t6_ready", 32'(sample_ready), 1);
    chk("t6_overrun", 32'(overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs();
    measure(0, 8'h00, 8'h00, len, hi);
    chk("t6_len", len, 256);
    chk("t6_high", hi, 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
